acc_seq: RTL and testbench

ACC_SEQ -- requirements
Module: acc_seq

---
 rtl/acc_seq_if.sv | 29 ++
 rtl/acc_seq.sv | 135 +++++++++++++
 tb/tb_acc_seq.sv | 377 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/acc_seq_if.sv
// Handshake and psum-memory bus for the accumulation sequencer.
// master = sequencer side, slave = memory/SFP/consumer side.
interface acc_seq_if #(
  parameter int psum_bw = 16,
  parameter int col     = 8
);
  logic                     start;
  logic                     busy;
  logic                     done;
  logic                     CEN_pmem;
  logic                     WEN_pmem;
  logic [10:0]              A_pmem;
  logic                     acc;
  logic                     acc_clr;
  logic [col*psum_bw-1:0]   sfp_out;
  logic [col*psum_bw-1:0]   out_data;
  logic                     out_valid;
  logic                     out_ready;

  modport master (
    input  start, sfp_out, out_ready,
    output busy, done, CEN_pmem, WEN_pmem, A_pmem, acc, acc_clr, out_data, out_valid
  );

  modport slave (
    output start, sfp_out, out_ready,
    input  busy, done, CEN_pmem, WEN_pmem, A_pmem, acc, acc_clr, out_data, out_valid
  );
endinterface

// File: rtl/acc_seq.sv
// Accumulation sequencer: per output pixel, clears the SFP, reads len_kij psums,
// accumulates them, captures the SFP result and hands it off with valid/ready.
module acc_seq #(
  parameter int psum_bw  = 16,
  parameter int col      = 8,
  parameter int len_kij  = 9,
  parameter int len_onij = 16
) (
  input  logic       clk,
  input  logic       reset,
  acc_seq_if.master  bus
);
  localparam int KW = $clog2(len_kij) + 1;
  localparam int OW = $clog2(len_onij) + 1;
  localparam logic [KW-1:0] K_LAST = KW'(len_kij - 1);
  localparam logic [OW-1:0] O_LAST = OW'(len_onij - 1);
  localparam logic [10:0]   A_STEP = 11'(len_onij);

  typedef enum logic [2:0] {IDLE, CLR, READ, TAIL, SETTLE, OUT, DONE} state_t;

  logic [1:0]             r_rst_sync;
  logic                   w_rst_n;
  state_t                 r_state;
  logic [KW-1:0]          r_k;
  logic [OW-1:0]          r_o;
  logic [OW-1:0]          w_o_inc;
  logic [10:0]            r_addr_nxt;
  logic [10:0]            r_a_pmem;
  logic                   r_busy;
  logic                   r_done;
  logic                   r_cen;
  logic                   r_acc;
  logic                   r_acc_clr;
  logic                   r_out_valid;
  logic [col*psum_bw-1:0] r_out_data;

  // Assertion is immediate; release reaches the FSM only after two rising edges.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_rst_sync <= '0;
    else        r_rst_sync <= {r_rst_sync[0], 1'b1};
  end
  assign w_rst_n = r_rst_sync[1];

  assign w_o_inc = r_o + 1'b1;

  // Address is k*len_onij + o built incrementally: seeded with o on entry to CLR,
  // stepped by len_onij per read; 11-bit wrap equals the truncated product.
  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_state     <= IDLE;
      r_k         <= '0;
      r_o         <= '0;
      r_addr_nxt  <= '0;
      r_a_pmem    <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_cen       <= 1'b1;
      r_acc       <= 1'b0;
      r_acc_clr   <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else begin
      r_done    <= 1'b0;
      r_cen     <= 1'b1;
      r_acc     <= 1'b0;
      r_acc_clr <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_state    <= CLR;
            r_busy     <= 1'b1;
            r_acc_clr  <= 1'b1;
            r_addr_nxt <= 11'(r_o);
          end
        end
        CLR: begin
          r_state    <= READ;
          r_k        <= '0;
          r_cen      <= 1'b0;
          r_a_pmem   <= r_addr_nxt;
          r_addr_nxt <= r_addr_nxt + A_STEP;
        end
        READ: begin
          r_acc <= 1'b1;
          if (r_k == K_LAST) begin
            r_state <= TAIL;
          end else begin
            r_k        <= r_k + 1'b1;
            r_cen      <= 1'b0;
            r_a_pmem   <= r_addr_nxt;
            r_addr_nxt <= r_addr_nxt + A_STEP;
          end
        end
        TAIL: begin
          r_state <= SETTLE;
        end
        SETTLE: begin
          r_state     <= OUT;
          r_out_data  <= bus.sfp_out;
          r_out_valid <= 1'b1;
        end
        OUT: begin
          if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            if (r_o < O_LAST) begin
              r_state    <= CLR;
              r_o        <= w_o_inc;
              r_acc_clr  <= 1'b1;
              r_addr_nxt <= 11'(w_o_inc);
            end else begin
              r_state <= DONE;
              r_done  <= 1'b1;
            end
          end
        end
        DONE: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
          r_o     <= '0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.CEN_pmem  = r_cen;
  assign bus.WEN_pmem  = 1'b1;
  assign bus.A_pmem    = r_a_pmem;
  assign bus.acc       = r_acc;
  assign bus.acc_clr   = r_acc_clr;
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
endmodule

// File: tb/tb_acc_seq.sv
// Bench for acc_seq: SFP model, bus monitors and per-feature scenario tasks
// checked against address/timing rules computed with plain arithmetic.
module tb_acc_seq;
  localparam int PB = 16;
  localparam int COL = 8;
  localparam int K = 9;
  localparam int N = 16;
  localparam int DW = COL * PB;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  acc_seq_if #(.psum_bw(PB), .col(COL)) bus ();
  acc_seq_if #(.psum_bw(PB), .col(COL)) bus1 ();

  acc_seq #(.psum_bw(PB), .col(COL), .len_kij(K), .len_onij(N)) u_dut (
    .clk(clk), .reset(reset), .bus(bus));
  acc_seq #(.psum_bw(PB), .col(COL), .len_kij(1), .len_onij(1)) u_dut1 (
    .clk(clk), .reset(reset), .bus(bus1));

  int n_checks = 0;
  int n_fail = 0;

  function automatic logic [DW-1:0] rep(input int v);
    rep = {COL{16'(v)}};
  endfunction

  // Expected address of the idx-th read in a pass: pixel-major, kernel-minor.
  function automatic int exp_addr(input int idx, input int kk, input int nn);
    int o, k;
    o = idx / kk;
    k = idx % kk;
    return (k * nn + o) % 2048;
  endfunction

  // SFP model: returns the pixel index only after exactly K accumulations.
  int sfp_pix = 0;
  int sfp_cnt = 0;
  always @(posedge clk) begin
    if (!bus.CEN_pmem) sfp_pix <= int'(bus.A_pmem) % N;
    if (bus.acc_clr)   sfp_cnt <= 0;
    else if (bus.acc)  sfp_cnt <= sfp_cnt + 1;
  end
  assign bus.sfp_out  = (sfp_cnt == K) ? rep(sfp_pix) : {COL{16'hDEAD}};
  assign bus1.sfp_out = rep(0);

  logic mon_clr = 1'b0;
  int cyc = 0;
  int start_cyc = 0, done_cyc = 0, n_done = 0, n_acc = 0, n_clr = 0, first_clr = -1;
  int first_acc = -1, pair_err = 0, stall_err = 0, n_stall = 0, wen_err = 0;
  int reads_q[$];
  int read_cyc_q[$];
  logic [DW-1:0] hs_q[$];
  logic prev_read = 1'b0, prev_valid = 1'b0, prev_ready = 1'b0;
  logic [DW-1:0] prev_data = '0;
  int start1_cyc = 0, done1_cyc = 0, n_done1 = 0, n_acc1 = 0, pair_err1 = 0, n_hs1 = 0;
  int reads1_q[$];
  logic prev_read1 = 1'b0;

  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (mon_clr) begin
        n_done = 0; n_acc = 0; n_clr = 0; first_clr = -1; first_acc = -1;
        pair_err = 0; stall_err = 0; n_stall = 0; wen_err = 0;
        reads_q.delete(); read_cyc_q.delete(); hs_q.delete();
        n_done1 = 0; n_acc1 = 0; pair_err1 = 0; n_hs1 = 0; reads1_q.delete();
      end
      if (!reset) begin
        prev_read = 1'b0; prev_valid = 1'b0; prev_read1 = 1'b0;
      end else begin
        if (bus.start && !bus.busy) start_cyc = cyc;
        if (!bus.CEN_pmem) begin
          reads_q.push_back(int'(bus.A_pmem));
          read_cyc_q.push_back(cyc);
        end
        if (bus.acc) begin
          n_acc++;
          if (first_acc < 0) first_acc = cyc;
        end
        if (bus.acc !== prev_read) pair_err++;
        if (bus.acc_clr) begin
          n_clr++;
          if (first_clr < 0) first_clr = cyc;
        end
        if (bus.WEN_pmem !== 1'b1) wen_err++;
        if (bus.done) begin n_done++; done_cyc = cyc; end
        if (bus.out_valid && (!bus.CEN_pmem || bus.acc)) stall_err++;
        if (bus.out_valid && prev_valid && !prev_ready && bus.out_data !== prev_data) stall_err++;
        if (bus.out_valid && !bus.out_ready) n_stall++;
        if (bus.out_valid && bus.out_ready) hs_q.push_back(bus.out_data);
        prev_read = !bus.CEN_pmem; prev_valid = bus.out_valid;
        prev_ready = bus.out_ready; prev_data = bus.out_data;
        if (bus1.start && !bus1.busy) start1_cyc = cyc;
        if (!bus1.CEN_pmem) reads1_q.push_back(int'(bus1.A_pmem));
        if (bus1.acc) n_acc1++;
        if (bus1.acc !== prev_read1) pair_err1++;
        if (bus1.done) begin n_done1++; done1_cyc = cyc; end
        if (bus1.out_valid && bus1.out_ready) n_hs1++;
        prev_read1 = !bus1.CEN_pmem;
      end
    end
  end

  task automatic clear_mon();
    @(posedge clk); #1 mon_clr = 1'b1;
    @(posedge clk); #1 mon_clr = 1'b0;
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 bus.start = 1'b1;
    @(posedge clk); #1 bus.start = 1'b0;
  endtask

  task automatic wait_done(input int max_cyc, output bit timed_out);
    timed_out = 1'b1;
    for (int i = 0; i < max_cyc; i++) begin
      @(posedge clk); #1;
      if (n_done > 0) begin timed_out = 1'b0; break; end
    end
  endtask

  task automatic check_pass_data(input string tag);
    int bad_a, bad_d;
    bad_a = 0; bad_d = 0;
    n_checks++;
    if (reads_q.size() !== N * K) begin
      n_fail++; $display("FAIL %s read_count got %0d exp %0d", tag, reads_q.size(), N * K);
    end
    for (int i = 0; i < reads_q.size() && i < N * K; i++)
      if (reads_q[i] !== exp_addr(i, K, N)) bad_a++;
    n_checks++;
    if (bad_a !== 0) begin n_fail++; $display("FAIL %s addresses got %0d bad exp 0", tag, bad_a); end
    n_checks++;
    if (hs_q.size() !== N) begin
      n_fail++; $display("FAIL %s handshakes got %0d exp %0d", tag, hs_q.size(), N);
    end
    for (int i = 0; i < hs_q.size(); i++) if (hs_q[i] !== rep(i)) bad_d++;
    n_checks++;
    if (bad_d !== 0) begin n_fail++; $display("FAIL %s out_data got %0d bad exp 0", tag, bad_d); end
    n_checks++;
    if (pair_err !== 0 || n_acc !== N * K) begin
      n_fail++; $display("FAIL %s acc got %0d cyc %0d unpaired exp %0d 0", tag, n_acc, pair_err, N * K);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; bus.start = 1'b0; bus.out_ready = 1'b1;
    bus1.start = 1'b0; bus1.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({bus.busy, bus.done, bus.acc, bus.acc_clr, bus.out_valid} !== 5'b0) begin
      n_fail++; $display("FAIL reset_flags got %b exp 00000",
        {bus.busy, bus.done, bus.acc, bus.acc_clr, bus.out_valid});
    end
    n_checks++;
    if ({bus.CEN_pmem, bus.WEN_pmem} !== 2'b11) begin
      n_fail++; $display("FAIL reset_mem_en got %b exp 11", {bus.CEN_pmem, bus.WEN_pmem});
    end
    n_checks++;
    if (bus.A_pmem !== 11'd0) begin n_fail++; $display("FAIL reset_addr got %0d exp 0", bus.A_pmem); end
    n_checks++;
    if (bus.out_data !== '0) begin n_fail++; $display("FAIL reset_data got %h exp 0", bus.out_data); end
    reset = 1'b1; bus.start = 1'b1;
    for (int e = 1; e <= 2; e++) begin
      @(posedge clk); #1;
      n_checks++;
      if (bus.busy !== 1'b0) begin
        n_fail++; $display("FAIL reset_release_edge%0d busy got %b exp 0", e, bus.busy);
      end
    end
    bus.start = 1'b0;
    repeat (3) @(posedge clk);
  endtask

  task automatic test_basic();
    bit to;
    clear_mon();
    bus.out_ready = 1'b1;
    pulse_start();
    wait_done(400, to);
    n_checks++;
    if (to) begin n_fail++; $display("FAIL basic_done_timeout got none exp done"); end
    n_checks++;
    if (done_cyc - start_cyc !== N * 13 + 1) begin
      n_fail++; $display("FAIL basic_done_latency got %0d exp %0d", done_cyc - start_cyc, N * 13 + 1);
    end
    n_checks++;
    if (first_clr - start_cyc !== 1 || read_cyc_q.size() < K || read_cyc_q[0] - first_clr !== 1) begin
      n_fail++; $display("FAIL basic_clr_then_read got clr %0d exp %0d", first_clr - start_cyc, 1);
    end
    n_checks++;
    if (read_cyc_q.size() < K || read_cyc_q[K-1] - read_cyc_q[0] !== K - 1) begin
      n_fail++; $display("FAIL basic_reads_consecutive got %0d reads exp %0d in a row", read_cyc_q.size(), K);
    end
    n_checks++;
    if (read_cyc_q.size() == 0 || first_acc - read_cyc_q[0] !== 1) begin
      n_fail++; $display("FAIL basic_first_acc got offset %0d exp 1", first_acc);
    end
    n_checks++;
    if (n_clr !== N || n_done !== 1 || wen_err !== 0) begin
      n_fail++; $display("FAIL basic_pulses got clr %0d done %0d wen %0d exp %0d 1 0", n_clr, n_done, wen_err, N);
    end
    check_pass_data("basic");
  endtask

  task automatic test_backpressure();
    bit to, found;
    logic [DW-1:0] held;
    int bad;
    clear_mon();
    found = 1'b0; bad = 0;
    pulse_start();
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      if (bus.out_valid && hs_q.size() == 3) begin found = 1'b1; break; end
    end
    n_checks++;
    if (!found) begin n_fail++; $display("FAIL bp_reach_pixel3 got none exp out_valid"); end
    held = bus.out_data;
    bus.out_ready = 1'b0;
    repeat (20) begin
      @(posedge clk); #1;
      if (bus.out_valid !== 1'b1 || bus.out_data !== held || !bus.CEN_pmem || bus.acc) bad++;
    end
    bus.out_ready = 1'b1;
    n_checks++;
    if (bad !== 0) begin n_fail++; $display("FAIL bp_hold got %0d bad cycles exp 0", bad); end
    n_checks++;
    if (held !== rep(3)) begin n_fail++; $display("FAIL bp_held_data got %h exp %h", held, rep(3)); end
    wait_done(400, to);
    n_checks++;
    if (to || done_cyc - start_cyc !== N * 13 + 1 + 20) begin
      n_fail++; $display("FAIL bp_done_latency got %0d exp %0d", done_cyc - start_cyc, N * 13 + 21);
    end
    n_checks++;
    if (n_stall !== 20 || stall_err !== 0) begin
      n_fail++; $display("FAIL bp_stall got %0d cycles %0d errs exp 20 0", n_stall, stall_err);
    end
    check_pass_data("backpressure");
  endtask

  task automatic test_ignored_start();
    bit to, found;
    clear_mon();
    found = 1'b0;
    pulse_start();
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      if (hs_q.size() == 5) begin found = 1'b1; break; end
    end
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (!found || bus.busy !== 1'b1) begin
      n_fail++; $display("FAIL ign_busy_at_pixel5 got %b exp 1", bus.busy);
    end
    pulse_start();
    wait_done(400, to);
    n_checks++;
    if (to || done_cyc - start_cyc !== N * 13 + 1) begin
      n_fail++; $display("FAIL ign_done_latency got %0d exp %0d", done_cyc - start_cyc, N * 13 + 1);
    end
    repeat (30) @(posedge clk);
    #1;
    n_checks++;
    if (n_done !== 1 || bus.busy !== 1'b0 || n_clr !== N) begin
      n_fail++; $display("FAIL ign_no_second_pass got done %0d busy %b clr %0d exp 1 0 %0d", n_done, bus.busy, n_clr, N);
    end
    check_pass_data("ignored_start");
  endtask

  task automatic test_reset_mid();
    bit to, found;
    clear_mon();
    found = 1'b0;
    pulse_start();
    for (int i = 0; i < 200; i++) begin
      @(negedge clk); #1;
      if (reads_q.size() == 7 * K + 5) begin found = 1'b1; break; end
    end
    n_checks++;
    if (!found || bus.CEN_pmem !== 1'b0 || int'(bus.A_pmem) !== 4 * N + 7) begin
      n_fail++; $display("FAIL rst_mid_position got addr %0d exp %0d", bus.A_pmem, 4 * N + 7);
    end
    reset = 1'b0;
    #1;
    n_checks++;
    if ({bus.busy, bus.done, bus.acc, bus.acc_clr, bus.out_valid, bus.CEN_pmem, bus.WEN_pmem} !== 7'b0000011
        || bus.A_pmem !== 11'd0 || bus.out_data !== '0) begin
      n_fail++; $display("FAIL rst_mid_immediate got %b addr %0d exp 0000011 0",
        {bus.busy, bus.done, bus.acc, bus.acc_clr, bus.out_valid, bus.CEN_pmem, bus.WEN_pmem}, bus.A_pmem);
    end
    repeat (4) @(posedge clk);
    #1 reset = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    n_checks++;
    if (n_done !== 0 || bus.busy !== 1'b0) begin
      n_fail++; $display("FAIL rst_mid_no_done got done %0d busy %b exp 0 0", n_done, bus.busy);
    end
    clear_mon();
    pulse_start();
    wait_done(400, to);
    n_checks++;
    if (reads_q.size() == 0 || reads_q[0] !== 0) begin
      n_fail++; $display("FAIL rst_mid_restart_addr got %0d exp 0", reads_q.size() ? reads_q[0] : -1);
    end
    n_checks++;
    if (to || done_cyc - start_cyc !== N * 13 + 1) begin
      n_fail++; $display("FAIL rst_mid_restart_latency got %0d exp %0d", done_cyc - start_cyc, N * 13 + 1);
    end
    check_pass_data("reset_restart");
  endtask

  task automatic test_random_ready();
    bit to;
    clear_mon();
    repeat ($urandom_range(0, 5)) @(posedge clk);
    pulse_start();
    to = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      bus.out_ready = ($urandom_range(0, 3) != 0);
      if (n_done > 0) begin to = 1'b0; break; end
    end
    bus.out_ready = 1'b1;
    n_checks++;
    if (to || done_cyc - start_cyc !== N * 13 + 1 + n_stall) begin
      n_fail++; $display("FAIL rand_done_latency got %0d exp %0d", done_cyc - start_cyc, N * 13 + 1 + n_stall);
    end
    n_checks++;
    if (stall_err !== 0) begin n_fail++; $display("FAIL rand_stall_hold got %0d errs exp 0", stall_err); end
    check_pass_data("random_ready");
  endtask

  task automatic test_sweep();
    bit to;
    clear_mon();
    @(posedge clk); #1 bus1.start = 1'b1;
    @(posedge clk); #1 bus1.start = 1'b0;
    to = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk); #1;
      if (n_done1 > 0) begin to = 1'b0; break; end
    end
    n_checks++;
    if (reads1_q.size() !== 1 || reads1_q[0] !== 0) begin
      n_fail++; $display("FAIL sweep_reads got %0d reads exp 1 at addr 0", reads1_q.size());
    end
    n_checks++;
    if (n_acc1 !== 1 || pair_err1 !== 0) begin
      n_fail++; $display("FAIL sweep_acc got %0d cyc %0d unpaired exp 1 0", n_acc1, pair_err1);
    end
    n_checks++;
    if (n_hs1 !== 1) begin n_fail++; $display("FAIL sweep_handshakes got %0d exp 1", n_hs1); end
    n_checks++;
    if (to || done1_cyc - start1_cyc !== 6) begin
      n_fail++; $display("FAIL sweep_done_latency got %0d exp 6", done1_cyc - start1_cyc);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_ignored_start();
    test_reset_mid();
    test_random_ready();
    test_sweep();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
